// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - dispatch/commit/read bundle between ROB, dispatcher and register file
interface register_file_if #(
    parameter int ROB_TAG_W = 5
);
    logic                 rdy;
    logic                 flush;
    logic                 issue_valid;
    logic [4:0]           issue_rd;
    logic [ROB_TAG_W-1:0] issue_tag;
    logic                 commit_valid;
    logic [4:0]           commit_rd;
    logic [31:0]          commit_res;
    logic [ROB_TAG_W-1:0] commit_dependency;
    logic [4:0]           rs1_idx;
    logic [4:0]           rs2_idx;
    logic [31:0]          rs1_val;
    logic [31:0]          rs2_val;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [ROB_TAG_W-1:0] rs1_tag;
    logic [ROB_TAG_W-1:0] rs2_tag;

    modport master (
        output rdy, flush, issue_valid, issue_rd, issue_tag,
               commit_valid, commit_rd, commit_res, commit_dependency,
               rs1_idx, rs2_idx,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );

    modport slave (
        input  rdy, flush, issue_valid, issue_rd, issue_tag,
               commit_valid, commit_rd, commit_res, commit_dependency,
               rs1_idx, rs2_idx,
        output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 architectural register file with per-register ROB rename tags
// Optional same-cycle commit-to-read bypass enabled by REGFILE_BYPASS_EN.
module register_file #(
    parameter int ROB_TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    register_file_if.slave   bus
);
    logic [31:0]          val_q [32];
    logic [31:0]          val_d [32];
    logic [ROB_TAG_W-1:0] tag_q [32];
    logic [ROB_TAG_W-1:0] tag_d [32];

    // Statement order encodes priority: commit clear, then flush, then issue (younger producer wins).
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            val_d[i] = val_q[i];
            tag_d[i] = tag_q[i];
        end
        if (bus.rdy) begin
            if (bus.commit_valid && (bus.commit_rd != 5'd0)) begin
                val_d[bus.commit_rd] = bus.commit_res;
                if (tag_q[bus.commit_rd] == bus.commit_dependency) begin
                    tag_d[bus.commit_rd] = '0;
                end
            end
            if (bus.flush) begin
                for (int i = 0; i < 32; i++) begin
                    tag_d[i] = '0;
                end
            end else if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
                tag_d[bus.issue_rd] = bus.issue_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // x0 needs no special read path: its state is reset to zero and never written.
    always_comb begin
        bus.rs1_val  = val_q[bus.rs1_idx];
        bus.rs1_tag  = tag_q[bus.rs1_idx];
        bus.rs1_busy = (tag_q[bus.rs1_idx] != '0);
        bus.rs2_val  = val_q[bus.rs2_idx];
        bus.rs2_tag  = tag_q[bus.rs2_idx];
        bus.rs2_busy = (tag_q[bus.rs2_idx] != '0);
`ifdef REGFILE_BYPASS_EN
        if (bus.rdy && bus.commit_valid && (bus.rs1_idx != 5'd0) &&
            (bus.commit_rd == bus.rs1_idx) &&
            (tag_q[bus.rs1_idx] == bus.commit_dependency)) begin
            bus.rs1_val  = bus.commit_res;
            bus.rs1_tag  = '0;
            bus.rs1_busy = 1'b0;
        end
        if (bus.rdy && bus.commit_valid && (bus.rs2_idx != 5'd0) &&
            (bus.commit_rd == bus.rs2_idx) &&
            (tag_q[bus.rs2_idx] == bus.commit_dependency)) begin
            bus.rs2_val  = bus.commit_res;
            bus.rs2_tag  = '0;
            bus.rs2_busy = 1'b0;
        end
`endif
    end
endmodule

// File: doc/register_file.md
# register_file

Architectural register file with rename tags, placed between the reorder buffer's commit port and the dispatcher. It holds 32 x 32-bit integer registers plus a per-register ROB tag naming the in-flight instruction that will next write each register. Dispatch tags a destination register. ROB commit writes the value and retires the tag if it still matches. The dispatcher reads two source operands per cycle as value-or-tag pairs.

## Interface
- `ROB_TAG_W`, default 5: width of ROB tags. Tag 0 is never allocated by the ROB and encodes "no producer".
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `rdy` input 1: global enable. When low, all state holds; reads stay live.
- `flush` input 1: misprediction flush, driven by the ROB `wrong_commit`.
- `issue_valid` input 1: dispatcher allocates a destination this cycle.
- `issue_rd` input 5: destination register of the allocated instruction.
- `issue_tag` input ROB_TAG_W: ROB entry allocated, i.e. the ROB `rename_rd`.
- `commit_valid` input 1: ROB commit strobe.
- `commit_rd` input 5: committed destination.
- `commit_res` input 32: committed value.
- `commit_dependency` input ROB_TAG_W: ROB entry being committed.
- `rs1_idx`, `rs2_idx` input 5 each: source register indices.
- `rs1_val`, `rs2_val` output 32 each: register value. Meaningful when busy is 0.
- `rs1_busy`, `rs2_busy` output 1 each: a producer is outstanding.
- `rs1_tag`, `rs2_tag` output ROB_TAG_W each: ROB tag of the producer. Reads 0 when not busy.

## Operation
- State:
  - `val[0..31]`, 32 bits each.
  - `tag[0..31]`, ROB_TAG_W bits each.
  - busy is defined as `tag != 0`; there is no separate busy flop.
- x0:
  - never written and never tagged.
  - reads always return val 0, busy 0, tag 0.
  - issue or commit with rd = 0 is ignored.
- Commit, applied when `rdy` is high, `commit_valid` is high and `commit_rd` != 0:
  - `val[commit_rd] <= commit_res` unconditionally. An in-order commit always carries the newest committed value.
  - `tag[commit_rd] <= 0` only if `tag[commit_rd] == commit_dependency` and the same-cycle issue does not target `commit_rd`.
- Issue, applied when `rdy` is high, `issue_valid` is high, `issue_rd` != 0 and `flush` is low:
  - `tag[issue_rd] <= issue_tag`.
  - Issue overrides a same-cycle commit clear on the same rd, because the younger producer wins.
- Flush, applied when `rdy` is high and `flush` is high:
  - all tags are cleared to 0.
  - a same-cycle commit still writes its value. The ROB asserts `wrong_commit` and the commit of the offending branch or jump in the same cycle.
  - issue is ignored.
- Reads are combinational from state, plus the bypass described under Configuration.
- `rdy` low: no state changes. Commit, issue and flush inputs are ignored.

## Timing
- Reset, asynchronous: all `val` = 0 and all `tag` = 0. Immediately after, all read outputs are 0 and busy is 0.
- Reset asserted mid-operation clears state without waiting for a clock edge.
- Write latency is 1 cycle. An issue or commit presented in cycle N is visible on non-bypassed reads from cycle N+1.
- Tag compare width is ROB_TAG_W. Tag values wrap within the ROB's range 1..ROB_SIZE-1; no arithmetic is performed here.
- Simultaneous issue and commit to the same rd with a matching tag:
  - val is updated.
  - tag becomes `issue_tag`.
  - busy stays 1 next cycle.
- Commit with a stale tag (rd re-tagged by a younger instruction): val is updated, tag is unchanged, busy stays 1.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- When defined, a source read in the same cycle as a matching commit is bypassed. The match condition is `commit_valid && rdy`, with `commit_rd == rsX_idx != 0` and `tag[rsX_idx] == commit_dependency`. The read then returns `rsX_val = commit_res`, `rsX_busy = 0` and `rsX_tag = 0`.
- When not defined, reads reflect only registered state. The dispatcher must then pick the value up from the ROB `Qi_valid`/`Vi_value` path.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle after writing x5 = 0x1234 -> rs1_idx = 5 returns val 0, busy 0, tag 0 without a clock edge.
- **Issue then commit:**
  - issue rd = 3, tag = 7 -> next cycle rs1 = 3 gives busy 1, tag 7.
  - commit rd = 3, dep = 7, res = 0xDEADBEEF -> next cycle busy 0, val 0xDEADBEEF.
  - with `REGFILE_BYPASS_EN`, the commit cycle itself already reads val 0xDEADBEEF, busy 0.
- **Stale commit:** issue rd = 4 tag 2, then rd = 4 tag 6; commit rd = 4 dep 2 res 0x11 -> val 0x11, busy 1, tag 6.
- **Same-cycle issue and commit:** tag[8] = 9; in one cycle commit rd = 8 dep 9 res 0x55 and issue rd = 8 tag 10 -> next cycle val 0x55, tag 10, busy 1.
- **Flush:**
  - tags on x1, x2 and x31 are set; flush with a same-cycle commit rd = 1 dep matching res 0x77 and issue rd = 2 tag 3.
  - next cycle: all busy 0, x1 = 0x77, x2 tag 0.
- **x0 and rdy:**
  - issue or commit rd = 0 with res 0xFF -> x0 reads 0, busy 0.
  - with `rdy` = 0, an issue rd = 9 tag 4 -> no change.
